// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM widths, default frame/timeout lengths and decoder FSM states
package pwm_pkg;
    localparam int PWM_DUTY_W = 8;
    localparam int PWM_PERIOD_DEF = 256;
    localparam int PWM_TIMEOUT_DEF = 512;
    typedef enum logic [1:0] {SEEK, HIGH, LOW} pwm_state_t;
endpackage

// File: rtl/pwm_decoder_8bit_if.sv
// pwm_decoder_8bit_if: PWM line towards the decoder, recovered duty and status back
interface pwm_decoder_8bit_if;
    import pwm_pkg::*;
    logic pwm_in;
    logic [PWM_DUTY_W-1:0] duty;
    logic duty_valid;
    logic period_err;
    logic stuck;
    modport master (output pwm_in, input duty, duty_valid, period_err, stuck);
    modport slave (input pwm_in, output duty, duty_valid, period_err, stuck);
endinterface

// File: rtl/pwm_in_conditioner.sv
// pwm_in_conditioner: 2-FF sync, optional majority filter (PWM_DECODER_GLITCH_FILTER_EN), edge detect
module pwm_in_conditioner (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [1:0] r_sync;
    logic r_lvl, r_prev, w_lvl_d;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    logic [2:0] r_maj;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_maj <= '0;
        else r_maj <= {r_maj[1:0], r_sync[1]};
    assign w_lvl_d = (r_maj[0] & r_maj[1]) | (r_maj[0] & r_maj[2]) | (r_maj[1] & r_maj[2]);
`else
    assign w_lvl_d = r_sync[1];
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {r_sync, r_lvl, r_prev} <= '0;
        else {r_sync, r_lvl, r_prev} <= {r_sync[0], i_pwm, w_lvl_d, r_lvl};
    assign o_level = r_lvl;
    assign o_rise = r_lvl & ~r_prev;
    assign o_fall = ~r_lvl & r_prev;
endmodule

// File: rtl/pwm_decoder_8bit.sv
// pwm_decoder_8bit: recovers the 8-bit duty of a PWM line, one strobe per frame; glitch filter via PWM_DECODER_GLITCH_FILTER_EN
module pwm_decoder_8bit
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD_DEF,
    parameter int TIMEOUT = PWM_TIMEOUT_DEF
) (
    input logic clk,
    input logic rst_n,
    pwm_decoder_8bit_if.slave bus
);
    localparam int PW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(PERIOD + 1);
    localparam int XW = HW > PWM_DUTY_W ? HW : PWM_DUTY_W;
    localparam logic [XW-1:0] DUTY_MAX = XW'((1 << PWM_DUTY_W) - 1);
    logic w_level, w_rise, w_fall, w_tmo;
    logic [PW-1:0] r_per_cnt, w_per_inc;
    logic [HW-1:0] r_hi_cnt, w_hi_inc;
    logic [XW-1:0] w_hi_x;
    logic [PWM_DUTY_W-1:0] r_duty, w_duty_meas;
    logic r_valid, r_err, r_stuck;
    pwm_state_t r_state;
    pwm_in_conditioner u_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_pwm  (bus.pwm_in),
        .o_level(w_level),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );
    assign w_per_inc = &r_per_cnt ? r_per_cnt : r_per_cnt + PW'(1);
    assign w_hi_inc = &r_hi_cnt ? r_hi_cnt : r_hi_cnt + HW'(1);
    // fires on the cycle whose increment would bring per_cnt to TIMEOUT
    assign w_tmo = r_per_cnt == PW'(TIMEOUT - 1);
    assign w_hi_x = XW'(r_hi_cnt);
    assign w_duty_meas = w_hi_x > DUTY_MAX ? '1 : w_hi_x[PWM_DUTY_W-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEEK;
            r_per_cnt <= '0;
            r_hi_cnt <= '0;
            r_duty <= '0;
            r_valid <= 1'b0;
            r_err <= 1'b0;
            r_stuck <= 1'b0;
        end else if (w_rise) begin
            r_valid <= r_state == LOW;
            if (r_state == LOW) begin
                r_duty <= w_duty_meas;
                r_err <= r_per_cnt != PW'(PERIOD);
            end
            r_state <= HIGH;
            r_per_cnt <= PW'(1);
            r_hi_cnt <= HW'(1);
            r_stuck <= 1'b0;
        end else if (w_tmo) begin
            r_valid <= 1'b1;
            r_duty <= w_level ? '1 : '0;
            r_err <= 1'b1;
            r_stuck <= 1'b1;
            r_per_cnt <= '0;
            r_hi_cnt <= '0;
            r_state <= r_state == HIGH && w_fall ? LOW : r_state;
        end else begin
            r_valid <= 1'b0;
            r_per_cnt <= w_per_inc;
            r_hi_cnt <= r_state == SEEK ? '0 : r_state == HIGH && !w_fall ? w_hi_inc : r_hi_cnt;
            r_state <= r_state == HIGH && w_fall ? LOW : r_state;
        end
    end
    assign bus.duty = r_duty;
    assign bus.duty_valid = r_valid;
    assign bus.period_err = r_err;
    assign bus.stuck = r_stuck;
endmodule

// File: tb/tb_pwm_decoder_8bit.sv
// tb_pwm_decoder_8bit: random and directed PWM frames checked against a frame-level reference model
module tb_pwm_decoder_8bit;
    localparam int PERIOD = 256;
    localparam int TIMEOUT = 512;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    typedef struct {integer c; integer duty; integer err; integer stuck;} ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    int base, last_fall;
    bit seen, pf, h1, h2;
    pwm_decoder_8bit_if u_if ();
    pwm_decoder_8bit #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (u_if.duty_valid === 1'b1)
            obs_q.push_back('{cyc, integer'(u_if.duty), integer'(u_if.period_err), integer'(u_if.stuck)});
    task automatic chk(string tag, integer got, integer expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask
    task automatic model_reset(int r);
        base = r;
        last_fall = r;
        seen = 0;
        pf = 0;
        h1 = 0;
        h2 = 0;
    endtask
    // Frame = rise to rise; the count restarts at each rise (rise cycle included) or timeout.
    task automatic model_step(bit v);
        int c, d;
        bit f;
        c = cyc + LAT;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
        f = (v & h1) | (v & h2) | (h1 & h2);
`else
        f = v;
`endif
        h2 = h1;
        h1 = v;
        if (f && !pf) begin
            if (seen) begin
                d = last_fall > base ? last_fall - base - 1 : 0;
                exp_q.push_back('{c, d > 255 ? 255 : d, integer'((c - 1 - base) != PERIOD), 0});
            end
            seen = 1;
            base = c - 1;
        end else if (c - base == TIMEOUT) begin
            exp_q.push_back('{c, f ? 255 : 0, 1, 1});
            base = c;
        end
        if (!f && pf) last_fall = c;
        pf = f;
    endtask
    task automatic drive(bit v, int n);
        repeat (n) begin
            u_if.pwm_in = v;
            model_step(v);
            @(posedge clk);
            #1;
        end
    endtask
    task automatic frame(int h, int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask
    task automatic check_strobes();
        int ne, no;
        ev_t e, o;
        ne = 0;
        no = 0;
        foreach (exp_q[i]) if (exp_q[i].c < cyc) ne++;
        foreach (obs_q[i]) if (obs_q[i].c < cyc) no++;
        chk("strobe_count", no, ne);
        repeat (ne < no ? ne : no) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk("strobe_cycle", o.c, e.c);
            chk("duty", o.duty, e.duty);
            chk("period_err", o.err, e.err);
            chk("stuck", o.stuck, e.stuck);
        end
        while (exp_q.size() > 0 && exp_q[0].c < cyc) void'(exp_q.pop_front());
        while (obs_q.size() > 0 && obs_q[0].c < cyc) void'(obs_q.pop_front());
    endtask
    initial begin
        int duties[4] = '{1, 128, 254, 255};
        int len, hi;
        u_if.pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_duty", u_if.duty, 0);
        chk("rst_valid", u_if.duty_valid, 0);
        chk("rst_err", u_if.period_err, 0);
        chk("rst_stuck", u_if.stuck, 0);
        rst_n = 1'b1;
        model_reset(cyc);
        drive(1'b0, 1100);
        check_strobes();
        repeat (4) frame(100, 156);
        check_strobes();
        foreach (duties[i]) begin
            repeat (3) frame(duties[i], 256 - duties[i]);
            check_strobes();
        end
        drive(1'b1, 1000);
        repeat (3) frame(50, 206);
        check_strobes();
        frame(120, 180);
        frame(120, 136);
        check_strobes();
        drive(1'b1, 80);
        drive(1'b0, 60);
        drive(1'b1, 1);
        drive(1'b0, 115);
        frame(80, 176);
        check_strobes();
        repeat (20) begin
            len = $urandom_range(0, 2) == 0 ? 256 : $urandom_range(200, 320);
            hi = $urandom_range(1, len - 1);
            frame(hi, len - hi);
        end
        check_strobes();
        repeat (2) frame(60, 196);
        drive(1'b1, 30);
        check_strobes();
        #3;
        rst_n = 1'b0;
        u_if.pwm_in = 1'b0;
        #1;
        chk("midrst_duty", u_if.duty, 0);
        chk("midrst_valid", u_if.duty_valid, 0);
        chk("midrst_err", u_if.period_err, 0);
        chk("midrst_stuck", u_if.stuck, 0);
        exp_q.delete();
        obs_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset(cyc);
        repeat (3) frame(77, 179);
        drive(1'b0, 12);
        check_strobes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pwm_decoder_8bit.md
# pwm_decoder_8bit

Receive-side counterpart of the 8-bit PWM LED drivers. The block measures an incoming pulse-width-modulated line (nominally a 256-cycle frame from a `pwm_8bit` instance, a loop-back pin or an external controller) and recovers its 8-bit duty cycle. Each completed frame produces a one-cycle `duty_valid` strobe. Constant-level lines are resolved by a timeout. It sits between an input pin and any logic that needs the duty value, e.g. the colour-wheel control or a self-test loop.

## Interface
- `PERIOD`, 256: expected frame length in clocks; range 2..65535.
- `TIMEOUT`, 512: clocks without a rising edge before a constant-level result is emitted; must be > `PERIOD`.
- `clk`  in  1  system clock (48 MHz on the board).
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `pwm_in`  in  1  asynchronous PWM line, active-high.
- `duty`  out  8  last measured duty; reset 0.
- `duty_valid`  out  1  one-cycle strobe, `duty`/`period_err` new this cycle; reset 0.
- `period_err`  out  1  last frame length ≠ `PERIOD` or timeout result; reset 0.
- `stuck`  out  1  high while line has had no rising edge for ≥ `TIMEOUT` clocks; reset 0.

## Operation
- Input path: 2-FF synchronizer, then a registered previous-sample for edge detection.
- Counters:
  - `per_cnt`: width clog2(`TIMEOUT`+1), saturating.
  - `hi_cnt`: width clog2(`PERIOD`+1), saturating.
- FSM states: SEEK, HIGH, LOW.
  - SEEK (after reset): ignore levels, clear counters; on synced rising edge → HIGH with `per_cnt`=1, `hi_cnt`=1. No strobe, because the first frame is partial.
  - HIGH: increment both counters each cycle; on falling edge → LOW (`per_cnt` still increments that cycle, `hi_cnt` does not).
  - LOW: increment `per_cnt`. On rising edge, emit a result: `duty`=min(`hi_cnt`,255), `period_err`=(`per_cnt`≠`PERIOD`), `duty_valid`=1. Then reload `per_cnt`=1, `hi_cnt`=1 → HIGH.
- Timeout applies in any state. When `per_cnt` reaches `TIMEOUT`, emit `duty`=255 if the synced level is high, else 0, with `period_err`=1. Set `stuck`=1, reset `per_cnt`=0 and `hi_cnt`=0, and stay in the same state. This repeats every `TIMEOUT` clocks while the line is static.
- `stuck` clears on the next synced rising edge. The frame that follows has `period_err`=1 because its length is wrong.
- Duty 255 from a `pwm_8bit` (255 high, 1 low) → 255. Duty 0 (never high) → 0 via timeout only.
- Simultaneous timeout and rising edge in the same cycle: the edge wins, a normal frame is emitted, and `stuck` clears.
- `rst_n` low mid-frame: all outputs and counters go to their reset values immediately, state → SEEK.

## Timing
- `pwm_in` change captured at clock edge N → synced at N+2 → FSM acts at N+3.
- `duty_valid` is registered and high for exactly the cycle after edge N+3.
- `duty` and `period_err` change only together with `duty_valid` and hold between strobes.
- Strobe rate in steady state: one per `PERIOD` clocks.

## Configuration
- `PWM_DECODER_GLITCH_FILTER_EN`:
  - Defined: a 3-sample majority filter sits after the synchronizer. Pulses of 1 clock are rejected and all latencies grow by 2 clocks (strobe at N+5).
  - Undefined: no filter; single-cycle pulses are counted as edges.

## Structure
- Shared package `pwm_pkg`:
  - FSM state enum (SEEK/HIGH/LOW).
  - `PWM_DUTY_W`=8.
  - Default `PERIOD`/`TIMEOUT` constants, also used by `pwm_8bit`.
- One sub-module, `pwm_in_conditioner`: synchronizer, optional majority filter and edge detect. Outputs are `level`, `rise` and `fall`.

## Test plan
- Drive from a `pwm_8bit` model with duty 100 and `PERIOD`=256 → after the first partial frame, strobes every 256 clocks with `duty`=100 and `period_err`=0.
- Sweep duty 1, 128, 254, 255 → `duty` equals the input value, `period_err`=0.
- Hold `pwm_in`=0 after reset → first strobe at 512 clocks with `duty`=0, `period_err`=1, `stuck`=1; repeats every 512 clocks.
- Hold `pwm_in`=1 for 1000 clocks, then resume duty 50 → strobe with `duty`=255 and `stuck`=1. The next frame strobes with `period_err`=1 and `stuck` clears. The following frame gives `duty`=50, `period_err`=0.
- Frame of 300 clocks with 120 high → `duty`=120, `period_err`=1.
- Assert `rst_n`=0 mid-HIGH → outputs 0 immediately; after release, the first strobe comes only after a full frame.
- With `PWM_DECODER_GLITCH_FILTER_EN`: inject a 1-clock high pulse in the LOW phase → no extra strobe, `duty` unchanged.
